ram_access_arbiter: RTL

- Shares the single DMA/RAM port between three requesters: decompress handler (0), file loader (1), host/CNN side (2).
- Round-robin arbitration and one-transaction-at-a-time sequencing of the DMA read/write strobes.
- Replaces the mode-selected data, address and write muxes in the coordinator. Bounds every DMA wait with a timeout.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_access_arbiter_rr_select.sv | 30 +++
 rtl/ram_access_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM access arbiter slice.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    localparam int unsigned REQ_DECOMP = 0;
    localparam int unsigned REQ_FILE   = 1;
    localparam int unsigned REQ_HOST   = 2;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_NREQ    = 3;
    localparam int unsigned DEF_TIMEOUT = 64;

    // Width of an index into n requesters; never zero so a lone requester still gets a bit.
    function automatic int unsigned ptrWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_rr_select.sv
// Combinational round-robin picker: first active request at or after the pointer.
module rr_select
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    int unsigned idx;

    // Scan NREQ positions starting at ptr, wrapping at NREQ.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single DMA/RAM port between NREQ requesters, one transaction at a time.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [ADDR_W-1:0]        dma_addr_o,
    output logic [DATA_W-1:0]        dma_wdata_o,
    output logic                     dma_read_o,
    output logic                     dma_write_o,
    input  logic [DATA_W-1:0]        dma_rdata_i,
    input  logic                     dma_done_read_i,
    input  logic                     dma_done_write_i
);

    localparam int unsigned      PTR_W    = ptrWidth(NREQ);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    arbState_t         state;
    arbState_t         nextState;
    logic [PTR_W-1:0]  ptrQ;
    logic [PTR_W-1:0]  ownerQ;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [CNT_W-1:0]  cntQ;
    logic              errQ;
    logic [DATA_W-1:0] rdataQ;
    logic              selValid;
    logic [PTR_W-1:0]  selIdx;
    logic              matchDone;
    logic              timedOut;

    rr_select #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) uSelect (
        .req    (req_i),
        .ptr    (ptrQ),
        .valid  (selValid),
        .winner (selIdx)
    );

    // State register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; only the done strobe matching the latched op ends the wait.
    always_comb begin
        nextState = state;
        matchDone = weQ ? dma_done_write_i : dma_done_read_i;
        timedOut  = (cntQ == CNT_LAST);
        case (state)
            IDLE:    if (selValid) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT:    if (matchDone || timedOut) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Transaction latches, wait counter, read data and round-robin pointer.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ptrQ   <= '0;
            ownerQ <= '0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            cntQ   <= '0;
            errQ   <= 1'b0;
            rdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (selValid) begin
                        ownerQ <= selIdx;
                        weQ    <= we_i[selIdx];
                        addrQ  <= addr_i[int'(selIdx)*ADDR_W +: ADDR_W];
                        wdataQ <= wdata_i[int'(selIdx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    cntQ <= '0;
                end
                WAIT: begin
                    cntQ <= cntQ + 1'b1;
                    if (matchDone) begin
                        errQ <= 1'b0;
                        if (!weQ) rdataQ <= dma_rdata_i;
                    end else if (timedOut) begin
                        errQ   <= 1'b1;
                        rdataQ <= '0;
                    end
                end
                RESP: begin
                    ptrQ <= (ownerQ == PTR_LAST) ? '0 : ownerQ + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the state and the latched transaction.
    always_comb begin
        gnt_o       = '0;
        done_o      = '0;
        err_o       = 1'b0;
        dma_read_o  = 1'b0;
        dma_write_o = 1'b0;
        dma_addr_o  = addrQ;
        dma_wdata_o = wdataQ;
        rdata_o     = rdataQ;
        if (state != IDLE) gnt_o[ownerQ] = 1'b1;
        if (state == RESP) begin
            done_o[ownerQ] = 1'b1;
            err_o          = errQ;
        end
        if (state == ISSUE || state == WAIT) begin
            dma_write_o = weQ;
            dma_read_o  = !weQ;
        end
    end

endmodule
